// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and flag indices for alu_pipe
package alu_pkg;

  // Opcode encoding; 9..15 are illegal.
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SUBR = 2;
  localparam int OP_OR   = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_XOR  = 6;
  localparam int OP_XNOR = 7;
  localparam int OP_MUL  = 8;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MUL_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  // Bit positions inside the registered flag vector.
  localparam int FLG_C  = 0;
  localparam int FLG_V  = 1;
  localparam int FLG_Z  = 2;
  localparam int FLG_N  = 3;
  localparam int FLG_E  = 4;
  localparam int NFLAGS = 5;

  // Two's-complement overflow of x+y given the operand and sum sign bits.
  function automatic logic add_ovf(input logic xs, input logic ys, input logic ss);
    return (xs == ys) && (ss != xs);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier, one bit per cycle
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               latch operands and begin (ignored otherwise)
//   mcand_in, mplier_in WIDTH-bit unsigned operands
//   done                one-cycle pulse after the WIDTH-th iteration
//   product             2*WIDTH-bit product, valid while done is high
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH:0]   step_sum;

  // {hi, lo} starts as {0, multiplier}; each step conditionally adds the
  // multiplicand into hi and shifts the whole pair right by one, so the
  // consumed multiplier bits are replaced by product bits from the top.
  always_comb begin
    step_sum = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {WIDTH{1'b0}})};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand <= mcand_in;
        hi    <= '0;
        lo    <= mplier_in;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        hi  <= step_sum[WIDTH:1];
        lo  <= {step_sum[0], lo[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = {hi, lo};

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with accumulator operand and iterative multiply
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input handshake; op, a, b, c_in, acc_sel payload
//   out_valid/out_ready        output handshake; result, result_hi and flags payload
//   c_out, ovf, zero, neg, err status flags of the presented result
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  logic [1:0]        state;
  logic [WIDTH-1:0]  acc;
  logic              out_valid_q;
  logic [WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]  result_hi_q;
  logic [NFLAGS-1:0] flags_q;

  logic              accept;
  logic              out_hs;
  logic              is_mul;
  logic [WIDTH-1:0]  opa;

  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic              cy;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  nx_result;
  logic [NFLAGS-1:0] nx_flags;

  logic              mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [NFLAGS-1:0] mul_flags;

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready = rst_n && (state == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign is_mul   = (op == OPW'(OP_MUL));
  // The accumulator register still holds its pre-handshake value here, which
  // is what an accept coinciding with an output handshake must see.
  assign opa      = acc_sel ? acc : a;

  // Single-cycle datapath. SUB and SUBR are expressed as x + ~y + 1 so one
  // adder serves all three arithmetic ops and carry/overflow fall out of it.
  always_comb begin
    x         = opa;
    y         = b;
    cy        = c_in;
    nx_result = '0;
    nx_flags  = '0;
    case (op)
      OPW'(OP_SUB): begin
        y  = ~b;
        cy = 1'b1;
      end
      OPW'(OP_SUBR): begin
        x  = b;
        y  = ~opa;
        cy = 1'b1;
      end
      default: ;
    endcase
    sum = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cy);

    case (op)
      OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_SUBR): begin
        nx_result       = sum[WIDTH-1:0];
        nx_flags[FLG_C] = sum[WIDTH];
        nx_flags[FLG_V] = add_ovf(x[WIDTH-1], y[WIDTH-1], sum[WIDTH-1]);
      end
      OPW'(OP_OR):   nx_result = opa | b;
      OPW'(OP_AND):  nx_result = opa & b;
      OPW'(OP_NOR):  nx_result = ~(opa | b);
      OPW'(OP_XOR):  nx_result = opa ^ b;
      OPW'(OP_XNOR): nx_result = ~(opa ^ b);
      default: begin
        // Illegal (MUL never reaches this path's registers).
        nx_result       = '0;
        nx_flags[FLG_E] = !is_mul;
      end
    endcase
    nx_flags[FLG_Z] = (nx_result == '0);
    nx_flags[FLG_N] = nx_result[WIDTH-1];
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && is_mul),
    .mcand_in (opa),
    .mplier_in(b),
    .done     (mul_done),
    .product  (mul_product)
  );

  always_comb begin
    mul_flags        = '0;
    mul_flags[FLG_Z] = (mul_product == '0);
    mul_flags[FLG_N] = mul_product[2*WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      acc         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      if (out_hs) begin
        acc <= result_q;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state       <= ST_MUL_BUSY;
              out_valid_q <= 1'b0;
            end else begin
              result_q    <= nx_result;
              result_hi_q <= '0;
              flags_q     <= nx_flags;
              out_valid_q <= 1'b1;
            end
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done) begin
            state       <= ST_DONE;
            result_q    <= mul_product[WIDTH-1:0];
            result_hi_q <= mul_product[2*WIDTH-1:WIDTH];
            flags_q     <= mul_flags;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_hs) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign c_out     = flags_q[FLG_C];
  assign ovf       = flags_q[FLG_V];
  assign zero      = flags_q[FLG_Z];
  assign neg       = flags_q[FLG_N];
  assign err       = flags_q[FLG_E];

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       acc_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       c_out;
  logic       ovf;
  logic       zero;
  logic       neg;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe #(.WIDTH(8), .OPW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .acc_sel  (acc_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result_hi(result_hi),
    .c_out    (c_out),
    .ovf      (ovf),
    .zero     (zero),
    .neg      (neg),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] o, input logic [7:0] aa,
                       input logic [7:0] bb, input logic ci, input logic as);
    in_valid = v;
    op       = o;
    a        = aa;
    b        = bb;
    c_in     = ci;
    acc_sel  = as;
  endtask

  // Waits (bounded) at negedges until out_valid; returns cycles waited.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, result, result_hi, c_out, ovf, zero, neg, err} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov=%b ir=%b r=%h rh=%h flags=%b%b%b%b%b, want all 0",
               out_valid, in_ready, result, result_hi, c_out, ovf, zero, neg, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops [4];
    logic [7:0] exp_r [4];
    logic [3:0] exp_f [4]; // {c_out, ovf, zero, neg}
    ops[0] = 4'd0; exp_r[0] = 8'h48; exp_f[0] = 4'b1000;
    ops[1] = 4'd1; exp_r[1] = 8'hA7; exp_f[1] = 4'b0101;
    ops[2] = 4'd4; exp_r[2] = 8'h50; exp_f[2] = 4'b0000;
    ops[3] = 4'd7; exp_r[3] = 8'h58; exp_f[3] = 4'b0000;
    out_ready = 1'b1;
    drive(1'b1, ops[0], 8'h77, 8'hD0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== exp_r[i] ||
          result_hi !== 8'h00 || {c_out, ovf, zero, neg, err} !== {exp_f[i], 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_%0d: got ov=%b ir=%b r=%h rh=%h cvzne=%b%b%b%b%b, want ov=1 ir=1 r=%h rh=00 cvzn=%b e=0",
                 i, out_valid, in_ready, result, result_hi, c_out, ovf, zero, neg, err, exp_r[i], exp_f[i]);
      end
      if (i < 3) drive(1'b1, ops[i+1], 8'h77, 8'hD0, 1'b1, 1'b0);
      else       drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic test_mul;
    int cyc;
    logic busy_ready_seen;
    busy_ready_seen = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 4'd8, 8'h77, 8'hD0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      if (in_ready !== 1'b0) busy_ready_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== 9) begin
      n_fail++;
      $display("FAIL mul_latency: got %0d cycles want 9", cyc);
    end
    n_checks++;
    if (busy_ready_seen || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_in_ready: in_ready high during MUL (now %b) want 0", in_ready);
    end
    n_checks++;
    if (result !== 8'hB0 || result_hi !== 8'h60 || {c_out, ovf, zero, neg, err} !== 5'b00000) begin
      n_fail++;
      $display("FAIL mul_result: got r=%h rh=%h cvzne=%b%b%b%b%b want r=b0 rh=60 cvzne=00000",
               result, result_hi, c_out, ovf, zero, neg, err);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_handshake: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_accumulator;
    int cyc;
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 8'h05, 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 8'h08) begin
      n_fail++;
      $display("FAIL acc_add: got ov=%b r=%h want ov=1 r=08", out_valid, result);
    end
    @(negedge clk);
    drive(1'b1, 4'd1, 8'hFF, 8'h02, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 8'h06 || c_out !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL acc_sub: got ov=%b r=%h c=%b v=%b want ov=1 r=06 c=1 v=0",
               out_valid, result, c_out, ovf);
    end
    @(negedge clk);
    drive(1'b1, 4'd8, 8'hFF, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_out(cyc);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 8'h00 || result_hi !== 8'h00 || zero !== 1'b1 || neg !== 1'b0) begin
      n_fail++;
      $display("FAIL acc_mul: got ov=%b r=%h rh=%h z=%b n=%b want ov=1 r=00 rh=00 z=1 n=0",
               out_valid, result, result_hi, zero, neg);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal_backpressure;
    logic held_ok;
    held_ok   = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 8'h33, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 4'hC, 8'h5A, 8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    // Keep a legal op pending: it must not be taken while the sink stalls.
    drive(1'b1, 4'd6, 8'hFF, 8'h0F, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || err !== 1'b1 || result !== 8'h00 || result_hi !== 8'h00 ||
        zero !== 1'b1 || neg !== 1'b0 || c_out !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_result: got ov=%b e=%b r=%h rh=%h z=%b n=%b c=%b v=%b want ov=1 e=1 r=00 rh=00 z=1 n=0 c=0 v=0",
               out_valid, err, result, result_hi, zero, neg, c_out, ovf);
    end
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || err !== 1'b1 || result !== 8'h00 || in_ready !== 1'b0) held_ok = 1'b0;
    end
    n_checks++;
    if (!held_ok) begin
      n_fail++;
      $display("FAIL illegal_hold: now ov=%b e=%b r=%h ir=%b want ov=1 e=1 r=00 ir=0 throughout",
               out_valid, err, result, in_ready);
    end
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_release: got ov=%b want 0", out_valid);
    end
    drive(1'b1, 4'd0, 8'hEE, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 8'h01) begin
      n_fail++;
      $display("FAIL illegal_acc_zero: got ov=%b r=%h want ov=1 r=01", out_valid, result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul;
    logic quiet;
    quiet     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'd8, 8'h77, 8'hD0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, result, result_hi, c_out, ovf, zero, neg, err} !== 23'd0) begin
      n_fail++;
      $display("FAIL midmul_reset: got ov=%b ir=%b r=%h rh=%h flags=%b%b%b%b%b want all 0",
               out_valid, in_ready, result, result_hi, c_out, ovf, zero, neg, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midmul_idle: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL midmul_no_partial: out_valid rose after abandoned MUL, want 0");
    end
    // acc_sel exercises the accumulator reset: 0 + 0x20.
    drive(1'b1, 4'd0, 8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 8'h20 || c_out !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midmul_fresh_add: got ov=%b r=%h c=%b e=%b want ov=1 r=20 c=0 e=0",
               out_valid, result, c_out, err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_accumulator();
    test_illegal_backpressure();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Accepts operand/opcode transactions over a valid/ready handshake and returns registered results with status flags over a second valid/ready handshake.
- Adds an accumulator operand mode and a multi-cycle shift-add multiply.
- Sits between an operand-issue sequencer and a result sink in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 4).
- OPW, 4, opcode width.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept input this cycle
- op  in  OPW  opcode (encoding below)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry in (ADD only)
- acc_sel  in  1  1 = use accumulator in place of operand A
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- result  out  WIDTH  result (MUL: low half)
- result_hi  out  WIDTH  MUL high half; 0 for all other ops
- c_out  out  1  carry flag
- ovf  out  1  signed overflow flag
- zero  out  1  result == 0 (MUL: full 2*WIDTH product == 0)
- neg  out  1  result MSB (MUL: result_hi MSB)
- err  out  1  illegal opcode

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, accumulator=0, out_valid=0, in_ready=0 while rst_n low. result, result_hi, c_out, ovf, zero, neg and err all 0.
- Opcodes:
  - 0 ADD = A+B+c_in
  - 1 SUB = A+~B+1
  - 2 SUBR = B+~A+1
  - 3 OR, 4 AND, 5 NOR, 6 XOR, 7 XNOR
  - 8 MUL = unsigned A*B, 2*WIDTH-bit product
  - 9..15 illegal
- Operand A is the accumulator when acc_sel=1, else input a. The accumulator value is sampled at the accept edge.
- Flags:
  - c_out is bit WIDTH of the (WIDTH+1)-bit sum for ADD/SUB/SUBR; for SUB/SUBR, 1 = no borrow.
  - ovf is signed two's-complement overflow of the same sum.
  - Logic ops, MUL and illegal ops: c_out=0, ovf=0.
- Illegal opcode: result=0, result_hi=0, err=1, zero=1, neg=0. Latency is the same as for single-cycle ops.
- Accept: transfer occurs on a rising edge with in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back issue while the sink drains.
- Single-cycle ops: the result is registered at the accept edge; out_valid=1 from the next cycle.
- MUL: at the accept edge the FSM enters MUL_BUSY and the multiplicand/multiplier are latched.
  - Exactly WIDTH shift-add iterations follow, one per cycle.
  - out_valid rises WIDTH+1 cycles after the accept edge.
  - in_ready=0 throughout MUL_BUSY and until the result is accepted.
- Output: result and flags hold stable while out_valid && !out_ready. out_valid clears on the out_ready edge unless a new accept occurs on the same edge.
- Accumulator: loads result on every output handshake (out_valid && out_ready), including after MUL (low half) and illegal ops (0).
- FSM:
  - IDLE -> MUL_BUSY on accept of MUL.
  - MUL_BUSY -> DONE after the WIDTH-th iteration.
  - DONE -> IDLE on output handshake.
  - Single-cycle ops stay in IDLE; out_valid is tracked by the output register.
- Simultaneous events: output handshake and new accept on the same edge means the new result replaces the old one and out_valid stays 1. An acc_sel input accepted on that same edge reads the pre-update accumulator.
- Reset mid-MUL: the operation is abandoned, the state returns to IDLE, and all outputs are cleared; no partial result is ever presented.
- Widths: all arithmetic is internally WIDTH+1 bits; MUL uses a 2*WIDTH product register; no truncation except as defined above.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_MUL
  - FSM state encoding IDLE/MUL_BUSY/DONE
  - flag-vector field indices
- One sub-module is natural: alu_mul_iter (shift-add multiplier) with start/done handshake and WIDTH parameter.
- Single-cycle ops stay inline in a combinational block in the top level.

Test Plan:
- WIDTH=8, a=0x77, b=0xD0, c_in=1, op=ADD -> next cycle result=0x48, c_out=1, ovf=0, zero=0, neg=0.
- Same operands, op=SUB -> result=0xA7, c_out=0, ovf=1, neg=1. Then op=AND -> 0x50. Then op=XNOR -> 0x58. Issue these back-to-back with out_ready=1 and check one result per cycle.
- op=MUL, a=0x77, b=0xD0 -> out_valid exactly 9 cycles after accept, result=0xB0, result_hi=0x60, in_ready=0 until handshake.
- Accumulator chain: ADD a=0x05, b=0x03, c_in=0 -> 0x08. Then acc_sel=1, b=0x02, op=SUB -> 0x06. Then acc_sel=1, op=MUL, b=0x00 -> result=0, zero=1.
- Backpressure plus illegal op: op=0xC with out_ready=0 for 5 cycles -> err=1, result=0 held stable, in_ready=0. Release -> handshake, accumulator=0.
- Assert rst_n=0 mid-MUL at iteration 4 -> out_valid=0 and all outputs 0 asynchronously. After release, state=IDLE, in_ready=1, and a fresh ADD completes normally.
